// File: rtl/fifo_push_arb_if.sv
// Requester and downstream-FIFO handshake bundle for fifo_push_arb.
// The arbiter connects through the slave modport; the requesters and FIFO side drive through the master modport.
interface fifo_push_arb_if #(
    parameter int WIDTH      = 128,
    parameter int NREQ       = 4,
    parameter int DEPTH_FULL = 18
);
    logic [NREQ-1:0]               req_vld;
    logic [NREQ*WIDTH-1:0]         req_data;
    logic [NREQ-1:0]               req_rdy;
    logic                          fifo_pop;
    logic                          fifo_push;
    logic [WIDTH-1:0]              fifo_din;
    logic [$clog2(NREQ)-1:0]       gnt_id;
    logic [$clog2(DEPTH_FULL):0]   credit;
    logic                          err_uflow;

    modport master (
        output req_vld, req_data, fifo_pop,
        input  req_rdy, fifo_push, fifo_din, gnt_id, credit, err_uflow
    );

    modport slave (
        input  req_vld, req_data, fifo_pop,
        output req_rdy, fifo_push, fifo_din, gnt_id, credit, err_uflow
    );
endinterface

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter from NREQ requesters into a credit-tracked FIFO; burst locking via FIFO_PUSH_ARB_BURST_EN.
// Latency: an accepted word is pushed exactly 1 cycle later.
// Backpressure: req_rdy is all-zero while credit is 0; a pop frees a slot that is usable from the next cycle.
module fifo_push_arb #(
    parameter int WIDTH      = 128,
    parameter int NREQ       = 4,
    parameter int DEPTH_FULL = 18,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_push_arb_if.slave    bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH_FULL) + 1;
    localparam int BW = $clog2(BURST_LEN + 1);
`ifdef FIFO_PUSH_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     lock_id_q, lock_id_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic              err_q, err_d;
    logic              push_q;
    logic [WIDTH-1:0]  din_q;
    logic [IW-1:0]     gnt_q;

    logic [IW-1:0]     rr_idx;
    logic [IW-1:0]     rr_win;
    logic              rr_hit;
    logic              lock_hold;
    logic [IW-1:0]     win_id;
    logic              win_vld;
    logic              accept;
    logic [WIDTH-1:0]  win_data;

    // Round-robin search starting one past the last winner.
    always_comb begin
        rr_hit = 1'b0;
        rr_win = '0;
        rr_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!rr_hit && bus.req_vld[rr_idx]) begin
                rr_hit = 1'b1;
                rr_win = rr_idx;
            end
        end
    end

    assign lock_hold = BURST_ON && (state_q == LOCK) && bus.req_vld[lock_id_q];
    assign win_id    = lock_hold ? lock_id_q : rr_win;
    assign win_vld   = lock_hold || rr_hit;
    assign accept    = win_vld && (credit_q != '0);
    assign win_data  = bus.req_data[int'(win_id)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_id_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // A dropped lock falls straight back to round-robin; a fresh winner starts a new lock.
    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        burst_cnt_d = burst_cnt_q;
        if (BURST_ON) begin
            if (state_q == LOCK && !lock_hold) begin
                state_d = IDLE;
            end
            if (accept) begin
                if (lock_hold) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (burst_cnt_q == BW'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                    end
                end else if (BURST_LEN > 1) begin
                    state_d     = LOCK;
                    lock_id_d   = win_id;
                    burst_cnt_d = BW'(1);
                end
            end
        end
    end

    always_comb begin
        bus.req_rdy = '0;
        if (accept) begin
            bus.req_rdy[win_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = accept ? win_id : rr_ptr_q;
        credit_d = credit_q;
        err_d    = err_q;
        if (bus.fifo_pop && credit_q == CW'(DEPTH_FULL)) begin
            err_d = 1'b1;
            if (accept) begin
                credit_d = credit_q - CW'(1);
            end
        end else if (accept && !bus.fifo_pop) begin
            credit_d = credit_q - CW'(1);
        end else if (!accept && bus.fifo_pop) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= IW'(NREQ - 1);
            credit_q <= CW'(DEPTH_FULL);
            err_q    <= 1'b0;
            push_q   <= 1'b0;
            din_q    <= '0;
            gnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            push_q   <= accept;
            if (accept) begin
                din_q <= win_data;
                gnt_q <= win_id;
            end
        end
    end

    assign bus.fifo_push = push_q;
    assign bus.fifo_din  = din_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.credit    = credit_q;
    assign bus.err_uflow = err_q;
endmodule
